biriscv_itcm_responder: RTL
===========================

Name: biriscv_itcm_responder

Overview:
Instruction-side memory responder: the slave end of the frontend's icache request/response interface (rd/flush/invalidate/pc/priv out, accept/valid/error/inst/page_fault back). It is a pipelined 64-bit instruction TCM with a fixed response latency, address-range error, user-privilege fault and flush/invalidate handling. A loader write port fills it before or between fetches. It replaces the icache in cacheless configurations and serves as the frontend test responder.

Parameters:
MEM_WORDS, 4096, number of 64-bit words; power of two
MEM_WORDS_W, 12, log2(MEM_WORDS)
BASE_ADDR, 32'h8000_0000, byte address of word 0
READ_LATENCY, 1, accept-to-valid cycles; legal 1..4
USER_LIMIT_ADDR, 32'h8000_4000, fetches at or above this address fault when priv is user
INVAL_CYCLES, 4, accept-blocked cycles after an invalidate; legal 1..255

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req_rd_i  in  1  fetch request valid
req_flush_i  in  1  discard in-flight responses
req_invalidate_i  in  1  start invalidate busy period
req_pc_i  in  32  fetch byte address
req_priv_i  in  2  privilege: 0=U, 1=S, 3=M
req_accept_o  out  1  request taken this cycle when high with req_rd_i
resp_valid_o  out  1  response strobe, one cycle, no backpressure
resp_inst_o  out  64  aligned 64-bit instruction pair
resp_error_o  out  1  address out of range
resp_page_fault_o  out  1  user fetch above USER_LIMIT_ADDR
load_wr_i  in  1  loader write strobe
load_addr_i  in  32  loader byte address
load_data_i  in  64  loader write data
load_accept_o  out  1  loader write taken

Behaviour:
- Reset (rst_i low, async): all response outputs 0, pipeline valid bits cleared, invalidate counter 0. req_accept_o and load_accept_o are 1 once reset deasserts. Memory contents are not reset.
- Accept: req_accept_o = !inval_busy && !load_wr_i. Loader has priority, so read and write never share a cycle. load_accept_o = !inval_busy.
- Indexing: idx = (pc - BASE_ADDR) >> 3, truncated to MEM_WORDS_W; pc[2:0] ignored. The whole aligned word is returned.
- Range check: in_range = pc >= BASE_ADDR && pc < BASE_ADDR + MEM_WORDS*8, using unsigned 33-bit compare so there is no wrap.
- Out-of-range fetch: error=1, inst=0, page_fault=0.
- Page fault: in_range && priv==0 && pc >= USER_LIMIT_ADDR. Gives page_fault=1 and inst=0. Error takes priority over page fault.
- Latency: the response for a request accepted at edge N appears in the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1 it is the cycle after accept.
  - Memory is read at the accept edge. Later loader writes to that word do not alter the response.
  - Delay stages form a shift register of {valid, inst, error, fault}.
  - Throughput is one request per cycle, responses in order, exactly one response per accepted request.
- Flush: req_flush_i high clears the valid bit of every stage holding a request accepted before this cycle, and resp_valid_o is forced 0 in the flush cycle. A request accepted in the same cycle as the flush is kept and returned.
- Invalidate: req_invalidate_i loads the counter with INVAL_CYCLES.
  - inval_busy = counter != 0; the counter decrements each cycle.
  - Accept is low from the cycle after the invalidate pulse for INVAL_CYCLES cycles. The invalidate cycle itself still accepts.
  - In-flight responses still drain.
  - Invalidate while busy reloads the counter.
  - Invalidate and flush together: both actions apply.
- Loader writes a full 64-bit word at idx(load_addr_i) when load_wr_i && load_accept_o. An out-of-range load address is accepted and dropped.
- Reset mid-operation: in-flight responses are lost and no stale valid appears after reset release.

Test Plan:
- Load 0x0000_0013_0000_0093 at 0x8000_0000; rd pc=0x8000_0004, priv=3, READ_LATENCY=1 -> next cycle valid=1, inst=0x0000_0013_0000_0093, error=0, fault=0.
- READ_LATENCY=3, back-to-back rd of 0x8000_0000, 0x8000_0008, 0x8000_0010 -> three consecutive valids starting 3 cycles after first accept, in order, correct data.
- rd pc=0x7FFF_FFF8 then pc=BASE+MEM_WORDS*8 -> both valid with error=1, inst=0; pc=0x8000_4000 priv=0 -> page_fault=1; same pc priv=1 -> normal data.
- READ_LATENCY=3, 2 requests in flight, flush with a new rd same cycle -> only the new request responds, 3 cycles later.
- invalidate pulse, INVAL_CYCLES=4 -> accept low exactly 4 cycles; in-flight response still delivered; second invalidate at busy cycle 2 extends busy to cycle 6.
- load_wr_i and req_rd_i together -> req_accept_o=0, write lands. rst_i low with READ_LATENCY=2 and 1 request in flight -> outputs 0, no response after release.

Source files
------------

// File: rtl/biriscv_itcm_responder.sv
// Instruction TCM responder for the frontend fetch interface: fixed-latency 64-bit
// reads with range/privilege checks, flush and invalidate handling, plus a loader port.
module biriscv_itcm_responder #(
    parameter int          MEM_WORDS       = 4096,
    parameter int          MEM_WORDS_W     = 12,
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
    parameter int          READ_LATENCY    = 1,
    parameter logic [31:0] USER_LIMIT_ADDR = 32'h8000_4000,
    parameter int          INVAL_CYCLES    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_rd_i,
    input  logic        req_flush_i,
    input  logic        req_invalidate_i,
    input  logic [31:0] req_pc_i,
    input  logic [1:0]  req_priv_i,
    output logic        req_accept_o,
    output logic        resp_valid_o,
    output logic [63:0] resp_inst_o,
    output logic        resp_error_o,
    output logic        resp_page_fault_o,
    input  logic        load_wr_i,
    input  logic [31:0] load_addr_i,
    input  logic [63:0] load_data_i,
    output logic        load_accept_o
);

    // Upper bound kept in 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 3);

    function automatic logic addr_in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
    endfunction

    function automatic logic [MEM_WORDS_W-1:0] addr_idx(input logic [31:0] a);
        return MEM_WORDS_W'((a - BASE_ADDR) >> 3);
    endfunction

    logic [63:0] mem_q [MEM_WORDS];

    logic [7:0] inval_cnt_q, inval_cnt_d;
    logic       inval_busy;

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] err_q, flt_q;
    logic [63:0]             inst_q [READ_LATENCY];

    logic                   req_fire;
    logic                   req_in_range;
    logic                   req_pg_fault;
    logic [MEM_WORDS_W-1:0] req_idx;
    logic [63:0]            rd_inst;
    logic                   load_fire;

    assign inval_busy    = (inval_cnt_q != 8'd0);
    assign req_accept_o  = !inval_busy && !load_wr_i;
    assign load_accept_o = !inval_busy;
    assign req_fire      = req_rd_i && req_accept_o;

    assign req_in_range = addr_in_range(req_pc_i);
    assign req_idx      = addr_idx(req_pc_i);
    assign req_pg_fault = req_in_range && (req_priv_i == 2'd0) && (req_pc_i >= USER_LIMIT_ADDR);
    assign rd_inst      = (req_in_range && !req_pg_fault) ? mem_q[req_idx] : 64'd0;

    // Out-of-range loader writes are accepted but never touch the array.
    assign load_fire = load_wr_i && load_accept_o && addr_in_range(load_addr_i);

    always_ff @(posedge clk_i) begin
        if (load_fire) begin
            mem_q[addr_idx(load_addr_i)] <= load_data_i;
        end
    end

    always_comb begin
        inval_cnt_d = inval_cnt_q;
        if (req_invalidate_i) begin
            inval_cnt_d = 8'(INVAL_CYCLES);
        end else if (inval_busy) begin
            inval_cnt_d = inval_cnt_q - 8'd1;
        end
    end

    // A flush kills everything already in flight; the request entering this edge survives.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = req_fire;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1] && !req_flush_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            inval_cnt_q <= 8'd0;
            vld_q       <= '0;
            err_q       <= '0;
            flt_q       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                inst_q[i] <= 64'd0;
            end
        end else begin
            inval_cnt_q <= inval_cnt_d;
            vld_q       <= vld_d;
            inst_q[0]   <= rd_inst;
            err_q[0]    <= !req_in_range;
            flt_q[0]    <= req_pg_fault;
            for (int i = 1; i < READ_LATENCY; i++) begin
                inst_q[i] <= inst_q[i-1];
                err_q[i]  <= err_q[i-1];
                flt_q[i]  <= flt_q[i-1];
            end
        end
    end

    assign resp_valid_o      = vld_q[READ_LATENCY-1] && !req_flush_i;
    assign resp_inst_o       = inst_q[READ_LATENCY-1];
    assign resp_error_o      = err_q[READ_LATENCY-1];
    assign resp_page_fault_o = flt_q[READ_LATENCY-1];

endmodule
